instr_mem_loader: RTL

- Writer side of the instruction-fetch program-load port.
- Collects a byte stream from the debug UART receiver, packs every 4 bytes into one 32-bit instruction word, and issues one-cycle write strobes (o_we / o_instr_data) into the instruction memory.
- Loading ends on the HALT word or on capacity overflow.
- Sits between uart_rx and instruction_fetch, under control of the debug unit.

---
 rtl/instr_mem_loader.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: program-load writer for the instruction memory.
// Packs a UART byte stream big-endian into NB_DATA-bit words and emits one
// write strobe per word. A load ends on HALT_WORD (which is still written)
// or when MAX_WORDS words have been written.
// Optional build macro LOADER_TIMEOUT_EN adds an inter-byte timeout that
// aborts the load after TIMEOUT_CYCLES idle cycles in LOAD.
module instr_mem_loader #(
  parameter int                 NB_DATA        = 32,
  parameter int                 NB_BYTE        = 8,
  parameter int                 MAX_WORDS      = 256,
  parameter logic [NB_DATA-1:0] HALT_WORD      = 32'hFFFFFFFF,
  parameter int                 TIMEOUT_CYCLES = 1000000
) (
  input  logic                             clk,
  input  logic                             i_rst_n,
  input  logic                             i_start,
  input  logic                             i_rx_valid,
  input  logic [NB_BYTE-1:0]               i_rx_data,
  output logic                             o_rx_ready,
  output logic                             o_we,
  output logic [NB_DATA-1:0]               o_instr_data,
  output logic [$clog2(MAX_WORDS+1)-1:0]   o_word_count,
  output logic                             o_busy,
  output logic                             o_done,
  output logic                             o_overflow,
  output logic                             o_timeout
);

  localparam int BYTES = NB_DATA / NB_BYTE;
  localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int ACC_W = NB_DATA - NB_BYTE;
  localparam int CNT_W = $clog2(MAX_WORDS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [BC_W-1:0]   byte_cnt_p0;
  logic [ACC_W-1:0]  word_p0;
  logic              byte_acc;
  logic              start_ok;
  logic              last_byte;
  logic [CNT_W-1:0]  count_inc;
  logic              tmo_hit;

  // Shift one more byte into the partial word (earliest byte ends up on top).
  function automatic logic [ACC_W-1:0] shift_in(input logic [ACC_W-1:0] acc,
                                                input logic [NB_BYTE-1:0] b);
    logic [NB_DATA-1:0] full;
    full = {acc, b};
    return full[ACC_W-1:0];
  endfunction

  // Complete a word: the partial accumulator holds the first BYTES-1 bytes.
  function automatic logic [NB_DATA-1:0] pack_word(input logic [ACC_W-1:0] acc,
                                                   input logic [NB_BYTE-1:0] b);
    return {acc, b};
  endfunction

  assign byte_acc  = i_rx_valid & o_rx_ready;
  assign start_ok  = i_start & ((state == IDLE) | (state == DONE));
  assign last_byte = (byte_cnt_p0 == BC_W'(BYTES - 1));
  assign count_inc = o_word_count + CNT_W'(1);

`ifdef LOADER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             timeout_q;

  // The final idle cycle that reaches TIMEOUT_CYCLES aborts the load.
  assign tmo_hit   = (state == LOAD) && !byte_acc &&
                     (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign o_timeout = timeout_q;

  // Idle-cycle counter: runs only in LOAD, restarts on every accepted byte.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmo_cnt <= '0;
    end else if ((state != LOAD) || byte_acc) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  // Sticky timeout flag, cleared when a new load is started.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      timeout_q <= 1'b0;
    end else if (tmo_hit) begin
      timeout_q <= 1'b1;
    end else if (start_ok) begin
      timeout_q <= 1'b0;
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign o_timeout = 1'b0;
`endif

  // Load FSM with all handshake/status outputs registered alongside the state.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      byte_cnt_p0  <= '0;
      word_p0      <= '0;
      o_rx_ready   <= 1'b0;
      o_we         <= 1'b0;
      o_instr_data <= '0;
      o_word_count <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_overflow   <= 1'b0;
    end else begin
      o_we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            state        <= LOAD;
            byte_cnt_p0  <= '0;
            word_p0      <= '0;
            o_rx_ready   <= 1'b1;
            o_word_count <= '0;
            o_busy       <= 1'b1;
            o_done       <= 1'b0;
            o_overflow   <= 1'b0;
          end
        end

        LOAD: begin
          if (byte_acc) begin
            if (last_byte) begin
              state        <= WRITE;
              byte_cnt_p0  <= '0;
              o_rx_ready   <= 1'b0;
              o_we         <= 1'b1;
              o_instr_data <= pack_word(word_p0, i_rx_data);
            end else begin
              byte_cnt_p0 <= byte_cnt_p0 + BC_W'(1);
              word_p0     <= shift_in(word_p0, i_rx_data);
            end
          end else if (tmo_hit) begin
            // Abort: the partial word is dropped and nothing is written.
            state       <= DONE;
            byte_cnt_p0 <= '0;
            word_p0     <= '0;
            o_rx_ready  <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b1;
          end
        end

        WRITE: begin
          o_word_count <= count_inc;
          if (o_instr_data == HALT_WORD) begin
            state  <= DONE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end else if (count_inc == CNT_W'(MAX_WORDS)) begin
            state      <= DONE;
            o_busy     <= 1'b0;
            o_done     <= 1'b1;
            o_overflow <= 1'b1;
          end else begin
            state      <= LOAD;
            o_rx_ready <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
